user_input_debounce: RTL and testbench

//  Conditions slow, bouncy board inputs (USER_DIPSW_FPGA, USER_PB_FPGA) before any logic consumes them.
//  It is the input-side counterpart to the registered LED output path.
//  Per bit: 2-FF synchronizer, then a stability counter. Produces a clean level and one-cycle

---
 rtl/user_io_pkg.sv | 10 +
 rtl/debounce_bit.sv | 69 ++++++
 rtl/user_input_debounce.sv | 55 +++++
 tb/tb_user_input_debounce.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/user_io_pkg.sv
// Shared constants and types for the board user-input conditioning path.
package user_io_pkg;

   localparam int unsigned USER_IO_W         = 4;
   localparam int unsigned DEBOUNCE_10MS_50M = 500000;
   localparam int unsigned DEBOUNCE_SIM      = 8;

   typedef logic [USER_IO_W-1:0] user_io_t;

endpackage : user_io_pkg

// File: rtl/debounce_bit.sv
// One input bit: 2-FF synchronizer, stability counter, debounced level and edge pulses.
module debounce_bit
   import user_io_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50M,
   parameter logic        INIT_VAL        = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_in,
   output logic level_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic change_c
);

   localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1_q,    s1_d;
   logic             sync_q,  sync_d;
   logic             level_q, level_d;
   logic             rise_q,  rise_d;
   logic             fall_q,  fall_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   // Count while the synchronized input disagrees with the level; any agreement restarts it.
   always_comb begin
      s1_d    = raw_in;
      sync_d  = s1_q;
      level_d = level_q;
      cnt_d   = '0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync_q;
            rise_d  = sync_q;
            fall_d  = ~sync_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      change_c = rise_d | fall_d;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q    <= INIT_VAL;
         sync_q  <= INIT_VAL;
         level_q <= INIT_VAL;
         cnt_q   <= '0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         sync_q  <= sync_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_out  = level_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

endmodule : debounce_bit

// File: rtl/user_input_debounce.sv
// Debounces the board DIP switches / push buttons; per-bit conditioning plus a combined change pulse.
module user_input_debounce
   import user_io_pkg::*;
#(
   parameter int unsigned     WIDTH           = USER_IO_W,
   parameter int unsigned     DEBOUNCE_CYCLES = DEBOUNCE_10MS_50M,
   parameter logic [WIDTH-1:0] INIT_VAL       = '1
) (
   input  logic             CLK_50M_FPGA,
   input  logic             GLOBAL_RESETN,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] level_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic             any_change
);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
      $error("user_input_debounce: DEBOUNCE_CYCLES must be >= 1");
   end

   logic [WIDTH-1:0] change_c;
   logic             any_change_q, any_change_d;

   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .INIT_VAL        (INIT_VAL[i])
      ) u_bit (
         .clk        (CLK_50M_FPGA),
         .rst_n      (GLOBAL_RESETN),
         .raw_in     (raw_in[i]),
         .level_out  (level_out[i]),
         .rise_pulse (rise_pulse[i]),
         .fall_pulse (fall_pulse[i]),
         .change_c   (change_c[i])
      );
   end

   // Built from the bits' next-pulse terms so it lands in the same cycle as the bit pulses.
   always_comb begin
      any_change_d = |change_c;
   end

   always_ff @(posedge CLK_50M_FPGA) begin
      if (!GLOBAL_RESETN) begin
         any_change_q <= 1'b0;
      end else begin
         any_change_q <= any_change_d;
      end
   end

   assign any_change = any_change_q;

endmodule : user_input_debounce

// File: tb/tb_user_input_debounce.sv
// Directed, table-driven check of user_input_debounce with an 8-cycle debounce window.
module tb_user_input_debounce;
   import user_io_pkg::*;

   localparam int unsigned W = USER_IO_W;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] raw;
   logic [W-1:0] level_out, rise_pulse, fall_pulse;
   logic         any_change;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   always #10 clk = ~clk;

   user_input_debounce #(
      .WIDTH           (W),
      .DEBOUNCE_CYCLES (DEBOUNCE_SIM),
      .INIT_VAL        (4'hF)
   ) dut (
      .CLK_50M_FPGA  (clk),
      .GLOBAL_RESETN (rst_n),
      .raw_in        (raw),
      .level_out     (level_out),
      .rise_pulse    (rise_pulse),
      .fall_pulse    (fall_pulse),
      .any_change    (any_change)
   );

   // Hold {rst_n, raw} for n edges; edges before the last expect lvl_mid and no pulses.
   typedef struct {
      logic         rst_n;
      logic [W-1:0] raw;
      int           n;
      logic [W-1:0] lvl_mid;
      logic [W-1:0] lvl;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      logic         any;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [W-1:0] rw, input int n,
                      input logic [W-1:0] mid, input logic [W-1:0] lvl,
                      input logic [W-1:0] ri, input logic [W-1:0] fa, input logic an);
      vec_t v;
      v.rst_n = r; v.raw = rw; v.n = n; v.lvl_mid = mid;
      v.lvl = lvl; v.rise = ri; v.fall = fa; v.any = an;
      vq.push_back(v);
   endtask

   // Structural pulse properties checked every cycle once out of time zero.
   always @(negedge clk) begin
      if (mon_en) begin
         check("rise_and_fall_exclusive", 32'(rise_pulse & fall_pulse), 32'h0);
         check("any_change_is_or", 32'(any_change), 32'(|(rise_pulse | fall_pulse)));
      end
   end

   initial begin
      rst_n = 1'b0;
      raw   = 4'hF;

      // reset, then idle with raw at the reset value
      add(1'b0, 4'hF, 3,  4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
      add(1'b1, 4'hF, 20, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
      // clean fall on bit 0, accepted on edge 10
      add(1'b1, 4'hE, 9,  4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
      add(1'b1, 4'hE, 1,  4'hF, 4'hE, 4'h0, 4'h1, 1'b1);
      add(1'b1, 4'hE, 6,  4'hE, 4'hE, 4'h0, 4'h0, 1'b0);
      // 5-cycle glitch on bit 1 rejected
      add(1'b1, 4'hC, 5,  4'hE, 4'hE, 4'h0, 4'h0, 1'b0);
      add(1'b1, 4'hE, 10, 4'hE, 4'hE, 4'h0, 4'h0, 1'b0);
      // bit 2 bounces for 6 cycles, then settles low
      for (int b = 0; b < 6; b++)
         add(1'b1, (b % 2 == 0) ? 4'hA : 4'hE, 1, 4'hE, 4'hE, 4'h0, 4'h0, 1'b0);
      add(1'b1, 4'hA, 9,  4'hE, 4'hE, 4'h0, 4'h0, 1'b0);
      add(1'b1, 4'hA, 1,  4'hE, 4'hA, 4'h0, 4'h4, 1'b1);
      add(1'b1, 4'hA, 2,  4'hA, 4'hA, 4'h0, 4'h0, 1'b0);
      // back to all-high: bits 0 and 2 rise together
      add(1'b1, 4'hF, 9,  4'hA, 4'hA, 4'h0, 4'h0, 1'b0);
      add(1'b1, 4'hF, 1,  4'hA, 4'hF, 4'h5, 4'h0, 1'b1);
      add(1'b1, 4'hF, 3,  4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
      // all four fall in one step
      add(1'b1, 4'h0, 9,  4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
      add(1'b1, 4'h0, 1,  4'hF, 4'h0, 4'h0, 4'hF, 1'b1);
      add(1'b1, 4'h0, 3,  4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      // all four rise in one step
      add(1'b1, 4'hF, 9,  4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
      add(1'b1, 4'hF, 1,  4'h0, 4'hF, 4'hF, 4'h0, 1'b1);
      add(1'b1, 4'hF, 2,  4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
      // bit 3 counts to 5, reset discards it, then a full count after release
      add(1'b1, 4'h7, 7,  4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
      add(1'b0, 4'h7, 2,  4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
      add(1'b1, 4'h7, 9,  4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
      add(1'b1, 4'h7, 1,  4'hF, 4'h7, 4'h0, 4'h8, 1'b1);
      add(1'b1, 4'h7, 2,  4'h7, 4'h7, 4'h0, 4'h0, 1'b0);

      foreach (vq[i]) begin
         for (int k = 0; k < vq[i].n; k++) begin
            bit last;
            @(negedge clk);
            rst_n = vq[i].rst_n;
            raw   = vq[i].raw;
            @(posedge clk);
            #1;
            mon_en = 1'b1;
            last = (k == vq[i].n - 1);
            check($sformatf("v%0d.e%0d level_out", i, k), 32'(level_out),
                  32'(last ? vq[i].lvl : vq[i].lvl_mid));
            check($sformatf("v%0d.e%0d rise_pulse", i, k), 32'(rise_pulse),
                  32'(last ? vq[i].rise : 4'h0));
            check($sformatf("v%0d.e%0d fall_pulse", i, k), 32'(fall_pulse),
                  32'(last ? vq[i].fall : 4'h0));
            check($sformatf("v%0d.e%0d any_change", i, k), 32'(any_change),
                  32'(last ? vq[i].any : 1'b0));
         end
      end

      // bit 3 toggling every cycle never settles: level holds 4'h7
      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         raw = (k % 2 == 0) ? 4'hF : 4'h7;
         @(posedge clk);
         #1;
         check("toggle level_out", 32'(level_out), 32'h7);
         check("toggle pulses", 32'(rise_pulse | fall_pulse), 32'h0);
      end

      // bit 3 then held high: rise on the 10th edge after the last toggle sample of 4'h7
      for (int k = 1; k <= 11; k++) begin
         @(negedge clk);
         raw = 4'hF;
         @(posedge clk);
         #1;
         check("settle level_out", 32'(level_out), (k >= 10) ? 32'hF : 32'h7);
         check("settle rise_pulse", 32'(rise_pulse), (k == 10) ? 32'h8 : 32'h0);
      end

      @(negedge clk);
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_user_input_debounce
